fmap_in_windowgen: RTL and testbench
====================================

FMAP_IN_WINDOWGEN -- requirements
Module: fmap_in_windowgen

Interface
REQ-001 SHALL have parameter H, default 4: input feature-map rows.
REQ-002 SHALL have parameter W, default 4: input feature-map columns.
REQ-003 SHALL have parameter D, default 2: channels per pixel, 1 bit each (binary activations).
REQ-004 SHALL have parameters FH, FW, defaults 3, 3: conv kernel height and width.
REQ-005 SHALL have parameters POOL_H, POOL_W, defaults 2, 2: pooling window.
REQ-006 SHALL have parameters STRIDE_H, STRIDE_W, defaults 1, 1: conv stride.
REQ-007 SHALL have parameter PAD, default 1: zero border on all four sides.
REQ-008 SHALL derive WH=(POOL_H-1)*STRIDE_H+FH, WW=(POOL_W-1)*STRIDE_W+FW, PH=H+2*PAD, PW=W+2*PAD, SH=POOL_H*STRIDE_H, SW=POOL_W*STRIDE_W.
REQ-009 clk  input  1  single clock; all state updates on its rising edge.
REQ-010 rst  input  1  reset, synchronous, active-low.
REQ-011 in_valid  input  1  data_in holds a pixel.
REQ-012 in_ready  output  1  block accepts data_in this cycle.
REQ-013 data_in  input  D  one pixel, raster order, row-major.
REQ-014 out_valid  output  1  data_out holds a complete window.
REQ-015 out_ready  input  1  consumer takes the window this cycle.
REQ-016 data_out  output  WH*WW*D  window; bits [((i*WW+j)*D)+:D] = window row i (0 = top), column j (0 = left).
REQ-017 frame_done  output  1  one-cycle pulse after the last window of a frame is accepted.

Function
REQ-018 SHALL walk the padded PH x PW frame with row counter r and column counter c; each step shifts one pixel into a line buffer of (WH-1)*PW+WW pixels.
REQ-019 SHALL shift D zero bits, without consuming input, when (r,c) is inside the padding border; in_ready SHALL be 0 there.
REQ-020 step condition: (!out_valid || out_ready) && (pad position || in_valid); in_ready = (!out_valid || out_ready) && !pad position && state RUN.
REQ-021 SHALL assert out_valid the cycle after a step at (r,c) with r>=WH-1, c>=WW-1, (r-WH+1)%SH==0, (c-WW+1)%SW==0; data_out SHALL reflect the buffer taps and remain stable while out_valid && !out_ready.
REQ-022 Windows SHALL never straddle a row wrap; the buffer is not cleared between rows.
REQ-023 Window accept and next step in the same cycle SHALL be allowed (no bubble).
REQ-024 States: RUN (stepping), LAST (final window pending), DONE (one cycle, frame_done=1, counters and buffer cleared), then RUN.
REQ-025 RUN->LAST on the step at (PH-1,PW-1); LAST->DONE when out_valid && out_ready; if the final position produces no window, RUN->DONE directly.
REQ-026 in_ready SHALL be 0 in LAST and DONE; next frame's first pixel accepted no earlier than the cycle after DONE.

Reset
REQ-027 While rst=0: in_ready=0, out_valid=0, frame_done=0, data_out=0, r=c=0, buffer all zero, state RUN.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first pixel after release is pixel (0,0) of a new frame.

Configuration
REQ-029 Macro FMAP_IN_WINDOWGEN_POS_EN: when defined, SHALL add outputs out_row and out_col ($clog2 of PH and PW bits), giving the window's top-left padded coordinate, valid with out_valid; when undefined, these ports and their logic SHALL not exist and all other behaviour is identical.

Verification
REQ-030 Defaults, in_valid=1, out_ready=1, pixels 0..15 (value k = k mod 4): exactly 4 windows at top-left (0,0),(0,2),(2,0),(2,2); frame done 36 steps after first step; frame_done pulses once.
REQ-031 Same, window (0,0): row 0 and column 0 all zero; window row 1, column 1 = pixel 0.
REQ-032 out_ready=0 for 10 cycles while out_valid=1: data_out unchanged, in_ready=0, no pixel lost; resumption yields the same 4 windows.
REQ-033 in_valid toggling 1/0 each cycle: identical window contents to REQ-030; pad steps continue without input.
REQ-034 rst=0 asserted after 7 pixels, released, full frame sent: 4 correct windows, no remnants of the aborted frame.
REQ-035 With FMAP_IN_WINDOWGEN_POS_EN defined: (out_row,out_col) = (0,0),(0,2),(2,0),(2,2) in order.

Source files
------------

// File: rtl/fmap_in_windowgen.sv
// Streams a zero-padded binary feature map through a line buffer and emits pooled-conv windows.
// Optional macro FMAP_IN_WINDOWGEN_POS_EN adds out_row/out_col (window top-left in padded coords).
module fmap_in_windowgen #(
  parameter int H        = 4,
  parameter int W        = 4,
  parameter int D        = 2,
  parameter int FH       = 3,
  parameter int FW       = 3,
  parameter int POOL_H   = 2,
  parameter int POOL_W   = 2,
  parameter int STRIDE_H = 1,
  parameter int STRIDE_W = 1,
  parameter int PAD      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [D-1:0] data_in,
  output logic out_valid,
  input  logic out_ready,
  output logic [((POOL_H-1)*STRIDE_H+FH)*((POOL_W-1)*STRIDE_W+FW)*D-1:0] data_out,
`ifdef FMAP_IN_WINDOWGEN_POS_EN
  output logic [$clog2(H+2*PAD)-1:0] out_row,
  output logic [$clog2(W+2*PAD)-1:0] out_col,
`endif
  output logic frame_done
);
  localparam int WH = (POOL_H-1)*STRIDE_H+FH;
  localparam int WW = (POOL_W-1)*STRIDE_W+FW;
  localparam int PH = H+2*PAD;
  localparam int PW = W+2*PAD;
  localparam int SH = POOL_H*STRIDE_H;
  localparam int SW = POOL_W*STRIDE_W;
  localparam int NB = (WH-1)*PW+WW;
  localparam int RW = $clog2(PH);
  localparam int CW = $clog2(PW);

  typedef enum logic [1:0] {RUN, LAST, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic [NB*D-1:0] buf_q, buf_d;
  logic            out_valid_q, out_valid_d;
  logic [D-1:0]    pix_in;
  logic            pad_pos, win_hit, last_pos, slot_free, step;
  int unsigned     ri, ci;
`ifdef FMAP_IN_WINDOWGEN_POS_EN
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
`endif

  always_comb begin
    ri        = 32'(r_q);
    ci        = 32'(c_q);
    pad_pos   = (ri < PAD) || (ri >= PAD+H) || (ci < PAD) || (ci >= PAD+W);
    win_hit   = (ri >= WH-1) && (ci >= WW-1) &&
                ((ri-(WH-1)) % SH == 0) && ((ci-(WW-1)) % SW == 0);
    last_pos  = (ri == PH-1) && (ci == PW-1);
    slot_free = !out_valid_q || out_ready;
    step      = (state_q == RUN) && slot_free && (pad_pos || in_valid);
    pix_in    = pad_pos ? '0 : data_in;
  end

  assign in_ready   = rst && (state_q == RUN) && slot_free && !pad_pos;
  assign out_valid  = out_valid_q;
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
`ifdef FMAP_IN_WINDOWGEN_POS_EN
    row_d       = row_q;
    col_d       = col_q;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      RUN: begin
        if (step) begin
          buf_d       = {buf_q[(NB-1)*D-1:0], pix_in};
          out_valid_d = win_hit;
`ifdef FMAP_IN_WINDOWGEN_POS_EN
          if (win_hit) begin
            row_d = RW'(ri-(WH-1));
            col_d = CW'(ci-(WW-1));
          end
`endif
          if (last_pos) begin
            state_d = win_hit ? LAST : DONE;
            r_d     = '0;
            c_d     = '0;
          end else if (ci == PW-1) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      LAST: if (out_valid_q && out_ready) state_d = DONE;
      DONE: begin
        state_d = RUN;
        r_d     = '0;
        c_d     = '0;
        buf_d   = '0;
      end
      default: state_d = RUN;
    endcase
  end

  // Window taps: element (i,j) entered the buffer (WH-1-i)*PW + (WW-1-j) steps ago.
  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < WH; i++)
      for (int unsigned j = 0; j < WW; j++)
        data_out[((i*WW+j)*D)+:D] = buf_q[(((WH-1-i)*PW)+(WW-1-j))*D+:D];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      r_q         <= '0;
      c_q         <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef FMAP_IN_WINDOWGEN_POS_EN
      row_q       <= '0;
      col_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
`ifdef FMAP_IN_WINDOWGEN_POS_EN
      row_q       <= row_d;
      col_q       <= col_d;
`endif
    end
  end

`ifdef FMAP_IN_WINDOWGEN_POS_EN
  assign out_row = row_q;
  assign out_col = col_q;
`endif

endmodule

// File: tb/tb_fmap_in_windowgen.sv
// Bench for fmap_in_windowgen: scenario table plus a geometric window reference model.
module tb_fmap_in_windowgen;
  localparam int H = 4, W = 4, D = 2, FH = 3, FW = 3;
  localparam int POOL_H = 2, POOL_W = 2, STRIDE_H = 1, STRIDE_W = 1, PAD = 1;
  localparam int WH = (POOL_H-1)*STRIDE_H+FH;
  localparam int WW = (POOL_W-1)*STRIDE_W+FW;
  localparam int PH = H+2*PAD;
  localparam int PW = W+2*PAD;
  localparam int SH = POOL_H*STRIDE_H;
  localparam int SW = POOL_W*STRIDE_W;
  localparam int OW = WH*WW*D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [D-1:0] data_in = '0;
  logic in_ready, out_valid, frame_done;
  logic [OW-1:0] data_out;
`ifdef FMAP_IN_WINDOWGEN_POS_EN
  logic [$clog2(PH)-1:0] out_row;
  logic [$clog2(PW)-1:0] out_col;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [OW-1:0] data;
    int row;
    int col;
  } win_t;

  typedef struct {
    int vmode;     // 0 always valid, 1 toggle, 2 random
    int rmode;     // 0 always ready, 2 random, 3 stall first window 10 cycles
    int abort_at;  // pixels accepted before a mid-frame reset, -1 none
    int rand_pix;
    int chk_first;
    int exp_win;
    int exp_fd;
    int exp_pix;
  } scen_t;

  win_t expq[$];
  logic [D-1:0] pix [H*W];
  scen_t tbl [7];

  always #5 clk = ~clk;

  fmap_in_windowgen #(
    .H(H), .W(W), .D(D), .FH(FH), .FW(FW), .POOL_H(POOL_H), .POOL_W(POOL_W),
    .STRIDE_H(STRIDE_H), .STRIDE_W(STRIDE_W), .PAD(PAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
`ifdef FMAP_IN_WINDOWGEN_POS_EN
    .out_row(out_row),
    .out_col(out_col),
`endif
    .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [D-1:0] padded(input int pr, input int pc);
    if (pr < PAD || pr >= PAD+H || pc < PAD || pc >= PAD+W) return '0;
    return pix[(pr-PAD)*W + (pc-PAD)];
  endfunction

  task automatic fill_pix(input int rnd);
    for (int k = 0; k < H*W; k++) pix[k] = rnd != 0 ? D'($urandom) : D'(k % 4);
  endtask

  task automatic build_expected();
    win_t e;
    expq.delete();
    for (int tr = 0; tr + WH <= PH; tr += SH)
      for (int tc = 0; tc + WW <= PW; tc += SW) begin
        e.data = '0;
        for (int i = 0; i < WH; i++)
          for (int j = 0; j < WW; j++)
            e.data[((i*WW+j)*D)+:D] = padded(tr+i, tc+j);
        e.row = tr;
        e.col = tc;
        expq.push_back(e);
      end
  endtask

  task automatic run_frame(input int vmode, input int rmode, input int abort_at, input int chk_first,
                           output int nwin, output int nfd, output int npix);
    int cyc, stall, abort_st;
    bit done;
    logic [OW-1:0] snap;
    logic [D-1:0] col0;
    win_t e;
    cyc = 0; stall = 0; abort_st = 0; done = 1'b0; snap = '0;
    nwin = 0; nfd = 0; npix = 0;
    while (!done) begin
      @(posedge clk); #1;
      rst = (abort_st == 0);
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom);
      endcase
      data_in = (npix < H*W) ? pix[npix] : D'($urandom);
      case (rmode)
        0:       out_ready = 1'b1;
        3:       out_ready = (stall >= 10);
        default: out_ready = 1'($urandom);
      endcase
      #1;
      if (abort_st == 2) begin
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_data_out", data_out, 0);
        check("abort_frame_done", frame_done, 0);
        done = 1'b1;
      end else if (abort_st == 1) begin
        check("abort_gate_in_ready", in_ready, 0);
        abort_st = 2;
      end else begin
        if (in_valid && in_ready) npix++;
        if (rmode == 3 && out_valid && !out_ready) begin
          if (stall == 0) snap = data_out;
          else check("stall_data_out", data_out, snap);
          check("stall_in_ready", in_ready, 0);
          stall++;
        end
        if (out_valid && out_ready) begin
          nwin++;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_window got=%0h expected=none", data_out);
          end else begin
            e = expq.pop_front();
            check("window_data", data_out, e.data);
`ifdef FMAP_IN_WINDOWGEN_POS_EN
            check("window_row", out_row, e.row);
            check("window_col", out_col, e.col);
`endif
          end
          if (chk_first != 0 && nwin == 1) begin
            col0 = '0;
            for (int i = 0; i < WH; i++) col0 |= data_out[((i*WW)*D)+:D];
            check("first_win_row0", data_out[WW*D-1:0], 0);
            check("first_win_col0", col0, 0);
            check("first_win_r1c1", data_out[((WW+1)*D)+:D], pix[0]);
          end
        end
        if (frame_done) begin
          nfd++;
          if (chk_first != 0) check("frame_done_cycle", cyc, 37);
          done = 1'b1;
        end
        if (abort_at >= 0 && npix == abort_at) abort_st = 1;
      end
      cyc++;
      if (!done && cyc > 2000) begin
        checks++;
        failures++;
        $display("FAIL timeout got=%0d cycles expected=frame_done", cyc);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int nw, nf, np;
    tbl[0] = '{0, 0, -1, 0, 1, 4, 1, 16};
    tbl[1] = '{0, 3, -1, 0, 0, 4, 1, 16};
    tbl[2] = '{1, 0, -1, 0, 0, 4, 1, 16};
    tbl[3] = '{0, 0,  7, 0, 0, 4, 1, 16};
    tbl[4] = '{2, 2, -1, 1, 0, 4, 1, 16};
    tbl[5] = '{2, 2, -1, 1, 0, 4, 1, 16};
    tbl[6] = '{1, 3, -1, 1, 0, 4, 1, 16};

    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_data_out", data_out, 0);

    for (int s = 0; s < 7; s++) begin
      if (tbl[s].abort_at >= 0) begin
        fill_pix(1);
        build_expected();
        run_frame(tbl[s].vmode, tbl[s].rmode, tbl[s].abort_at, 0, nw, nf, np);
      end
      fill_pix(tbl[s].rand_pix);
      build_expected();
      run_frame(tbl[s].vmode, tbl[s].rmode, -1, tbl[s].chk_first, nw, nf, np);
      check("window_count", nw, tbl[s].exp_win);
      check("frame_done_pulses", nf, tbl[s].exp_fd);
      check("pixels_taken", np, tbl[s].exp_pix);
      check("windows_left", expq.size(), 0);
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_frame_done", frame_done, 0);
      check("idle_out_valid", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
